// File: rtl/prog_loader_pkg.sv
// Shared CPU-side definitions: word width and loader state encoding.
package prog_loader_pkg;
    localparam int WORD_SIZE = 32;
    localparam int COUNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;
endpackage

// File: rtl/prog_loader.sv
// Program loader: packs a big-endian byte stream into words and writes them to memory.
// Latency: one write cycle per 4 accepted bytes; byte_ready is high only while collecting.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] base_addr,
    input  logic [COUNT_W-1:0]   word_count,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 mem_on,
    output logic                 mem_w,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 busy,
    output logic                 done
);
    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_data_q, mem_data_d;
    logic [COUNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]           idx_q, idx_d;
    logic                 byte_fire;

    assign byte_ready  = (state_q == COLLECT);
    assign byte_fire   = byte_valid & byte_ready;
    assign mem_on      = (state_q == WRITE);
    assign mem_w       = (state_q == WRITE);
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_q;
    assign busy        = (state_q == COLLECT) || (state_q == WRITE);
    assign done        = (state_q == FINISH);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    idx_d       = 2'd0;
                    word_d      = '0;
                    state_d     = (word_count == '0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_fire) begin
                    // ~idx maps byte 0 to lane 3, so the first byte lands in [31:24]
                    word_d[{~idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mem_addr_d = addr_q;
                        mem_data_d = word_d;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d      = addr_q + 32'd1;
                remaining_d = remaining_q - 16'd1;
                idx_d       = 2'd0;
                state_d     = (remaining_q == 16'd1) ? FINISH : COLLECT;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomised-handshake bench for prog_loader with a write scoreboard.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [WORD_SIZE-1:0] base_addr = '0;
    logic [COUNT_W-1:0]   word_count = '0;
    logic                 byte_valid = 1'b0;
    logic [7:0]           byte_data = '0;
    logic                 byte_ready, mem_on, mem_w, busy, done;
    logic [WORD_SIZE-1:0] mem_addr, mem_data_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ready_cnt = 0;
    int bad_on = 0;
    int bad_busy = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int obs_cyc[$];
    int done_cyc[$];

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_on(mem_on), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_w) begin
            obs_q.push_back({mem_addr, mem_data_in});
            obs_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (byte_ready) ready_cnt++;
        if (mem_on !== mem_w) bad_on++;
        if ((mem_w && !busy) || (done && busy) || (byte_ready && !busy)) bad_busy++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one load, pushing expected writes as the bytes are built, then drains the scoreboard.
    task automatic run_load(input logic [31:0] base, input logic [15:0] cnt, input bit rnd,
                            input logic [31:0] w0);
        logic [31:0] w;
        logic [7:0]  bq[$];
        logic [63:0] e, o;
        int sent, budget;
        obs_q.delete(); obs_cyc.delete(); done_cyc.delete(); exp_q.delete();
        ready_cnt = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            w = (i == 0) ? w0 : $urandom;
            exp_q.push_back({base + 32'(i), w});
            for (int b = 3; b >= 0; b--) bq.push_back(w[b*8 +: 8]);
        end
        base_addr = base; word_count = cnt; start = 1'b1; byte_valid = 1'b0;
        @(negedge clk); start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = 16'($urandom);
        sent = 0; budget = 0;
        while (sent < bq.size() && budget < 4000) begin
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            byte_data  = bq[sent];
            @(negedge clk);
            if (byte_valid && byte_ready) sent++;
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        checks++;
        if (sent != bq.size()) begin
            errors++;
            $display("FAIL bytes_accepted: got %0d want %0d", sent, bq.size());
        end
        byte_valid = 1'b1; byte_data = 8'hEE;
        budget = 0;
        while (done_cyc.size() == 0 && budget < 200) begin
            @(posedge clk); #1; budget++;
        end
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL write_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL write_addr_data: got %016h want %016h", o, e);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; byte_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
        checks++;
        if ({byte_ready, mem_on, mem_w, busy, done} !== 5'b0 || mem_addr !== '0 || mem_data_in !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/on/w/busy/done=%b addr=%h data=%h want all zero",
                     {byte_ready, mem_on, mem_w, busy, done}, mem_addr, mem_data_in);
        end
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; word_count = 16'd1; base_addr = 32'h5;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_start: got busy=%b ready=%b want 0 0", busy, byte_ready);
        end
    endtask

    task automatic test_single();
        run_load(32'h10, 16'd1, 1'b0, 32'h12345678);
        checks++;
        if (obs_cyc.size() != 1 || obs_cyc[0] - start_cyc != 5) begin
            errors++;
            $display("FAIL single_write_timing: got %0d writes, first offset %0d want 1 at 5",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] - start_cyc : -1);
        end
        checks++;
        if (done_cyc.size() < 1 || done_cyc[0] - start_cyc != 6) begin
            errors++;
            $display("FAIL single_done_timing: got offset %0d want 6",
                     (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1);
        end
    endtask

    task automatic test_multi();
        run_load(32'h10, 16'd3, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_cyc.size() != 3 || obs_cyc[i] - start_cyc != 5 + 5 * i) begin
                errors++;
                $display("FAIL multi_write_spacing[%0d]: got offset %0d want %0d", i,
                         (obs_cyc.size() > i) ? obs_cyc[i] - start_cyc : -1, 5 + 5 * i);
            end
        end
        checks++;
        if (done_cyc.size() < 1 || done_cyc[0] - start_cyc != 16) begin
            errors++;
            $display("FAIL multi_done_timing: got offset %0d want 16",
                     (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1);
        end
    endtask

    task automatic test_zero();
        run_load(32'h40, 16'd0, 1'b0, 32'h0);
        checks++;
        if (done_cyc.size() < 1 || done_cyc[0] - start_cyc != 1) begin
            errors++;
            $display("FAIL zero_done_timing: got offset %0d want 1",
                     (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1);
        end
        checks++;
        if (ready_cnt != 0) begin
            errors++;
            $display("FAIL zero_byte_ready: got %0d ready cycles want 0", ready_cnt);
        end
    endtask

    task automatic test_random_valid();
        run_load(32'h100, 16'd6, 1'b1, 32'hA5A55A5A);
    endtask

    task automatic test_reset_mid();
        obs_q.delete(); obs_cyc.delete(); done_cyc.delete();
        base_addr = 32'h30; word_count = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'hA1;
        @(posedge clk); #1;
        byte_data = 8'hA2;
        @(posedge clk); #1;
        byte_data = 8'hA3; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; byte_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || mem_addr !== '0 || mem_data_in !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: got busy=%b ready=%b addr=%h data=%h want 0 0 0 0",
                     busy, byte_ready, mem_addr, mem_data_in);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d writes %0d dones want 0 0",
                     obs_q.size(), done_cyc.size());
        end
        run_load(32'h20, 16'd2, 1'b0, 32'h0BADBEEF);
    endtask

    task automatic test_wrap();
        run_load(32'hFFFFFFFF, 16'd2, 1'b0, 32'h01020304);
    endtask

    task automatic test_signals();
        checks++;
        if (bad_on != 0 || bad_busy != 0) begin
            errors++;
            $display("FAIL strobe_busy_consistency: got %0d mem_on and %0d busy violations want 0 0",
                     bad_on, bad_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_random_valid();
        test_reset_mid();
        test_wrap();
        test_signals();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
